systolic_skew_feeder: RTL

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

---
 rtl/systolic_skew_feeder.sv | 106 ++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: skews operand beats into a systolic array and sequences pass stream/drain/done.
// Optional FEEDER_PARITY_EN adds per-word parity outputs aligned with the skewed buses.
module skew_lines #(
  parameter int N = 2,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [N*W-1:0] din,
  output logic [N*W-1:0] dout
`ifdef FEEDER_PARITY_EN
  ,
  output logic [N-1:0]   par
`endif
);
  for (genvar i = 0; i < N; i++) begin : g
    logic [W-1:0] sr [0:i];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) sr[j] <= '0;
      end else begin
        sr[0] <= load ? din[i*W +: W] : '0;
        for (int j = 1; j <= i; j++) sr[j] <= sr[j-1];
      end
    end
    assign dout[i*W +: W] = sr[i];
`ifdef FEEDER_PARITY_EN
    logic [i:0] pr;
    always_ff @(posedge clk) begin
      if (rst) begin
        pr <= '0;
      end else begin
        pr[0] <= load ? ^din[i*W +: W] : 1'b0;
        for (int j = 1; j <= i; j++) pr[j] <= pr[j-1];
      end
    end
    assign par[i] = pr[i];
`endif
  end
endmodule

module systolic_skew_feeder #(
  parameter int ROWS      = 2,
  parameter int COLS      = 2,
  parameter int WORD_SIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [ROWS*WORD_SIZE-1:0] in_left,
  input  logic [COLS*WORD_SIZE-1:0] in_top,
  output logic [ROWS*WORD_SIZE-1:0] left_in_bus,
  output logic [COLS*WORD_SIZE-1:0] top_in_bus,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               beat_count
`ifdef FEEDER_PARITY_EN
  ,
  output logic [ROWS-1:0]           left_par_bus,
  output logic [COLS-1:0]           top_par_bus
`endif
);
  localparam int DRAIN_CYCLES = (ROWS > COLS ? ROWS : COLS) - 1 + ROWS + COLS - 1;
  localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [15:0] cnt;
  logic accept;
  assign in_ready = !rst && (state == IDLE || state == STREAM);
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      beat_count <= '0;
    end else begin
      if (accept) beat_count <= beat_count + 16'd1;
      if (state == DONE) begin
        state <= IDLE;
        beat_count <= '0;
      end else if (state == DRAIN) begin
        state <= cnt == 16'(DRAIN_CYCLES - 1) ? DONE : DRAIN;
        cnt <= cnt + 16'd1;
      end else if (accept) begin
        state <= in_last ? DRAIN : STREAM;
        cnt <= '0;
      end
    end
  end
  skew_lines #(.N(ROWS), .W(WORD_SIZE)) u_left (
    .clk(clk), .rst(rst), .load(accept), .din(in_left), .dout(left_in_bus)
`ifdef FEEDER_PARITY_EN
    , .par(left_par_bus)
`endif
  );
  skew_lines #(.N(COLS), .W(WORD_SIZE)) u_top (
    .clk(clk), .rst(rst), .load(accept), .din(in_top), .dout(top_in_bus)
`ifdef FEEDER_PARITY_EN
    , .par(top_par_bus)
`endif
  );
endmodule
